ofm_writer: RTL and testbench

- Output-side counterpart of the CONV_ACC ifm/weight dispatch path.
- Consumes the ofm_port0/ofm_port1 valid-qualified result streams from CONV_ACC.
- Reconstructs the (channel, row, column) position of each result from the tiled emission order.
- Drains results through a small FIFO into a linear output memory over a ready/valid write port.

---
 rtl/ofm_writer.sv | 236 +++++++++++++++++++++++
 tb/tb_ofm_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ofm_writer : places tiled CONV_ACC ofm results into a linear output memory.
// Rev 1.0
// ----------------------------------------------------------------------------
module ofm_writer #(
  parameter int DATA_W     = 25,
  parameter int TI         = 16,
  parameter int TW_NUM     = 4,
  parameter int BAND       = 5,
  parameter int OFM_H      = 65,
  parameter int NUM_CO     = 8,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] ofm_port0,
  input  logic              ofm_port0_v,
  input  logic [DATA_W-1:0] ofm_port1,
  input  logic              ofm_port1_v,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_proto
);

  localparam int OFM_W     = TI * TW_NUM;
  localparam int NB        = OFM_H / BAND;
  localparam int CO_STRIDE = OFM_H * OFM_W;
  localparam int OW_W      = (TI > 1) ? $clog2(TI) : 1;
  localparam int BR_W      = $clog2(BAND + 2);
  localparam int TW_W      = (TW_NUM > 1) ? $clog2(TW_NUM) : 1;
  localparam int BD_W      = (NB > 1) ? $clog2(NB) : 1;
  localparam int OC_W      = (NUM_CO > 1) ? $clog2(NUM_CO) : 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int ENT_W     = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  logic              busy_q, done_q, err_ovf_q, err_proto_q;
  logic [OW_W-1:0]   ow_q, ow_d;
  logic [BR_W-1:0]   brow_q, brow_d, brow_sum;
  logic [TW_W-1:0]   tw_q, tw_d;
  logic [BD_W-1:0]   band_q, band_d;
  logic [OC_W-1:0]   oc_q, oc_d;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, wr_ptr1, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, remain, free;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              want0, want1, brow_last, proto, pop, acc0, acc1, ovf, last;
  logic [ADDR_W-1:0] addr0;
  logic [ENT_W-1:0]  word0, word1, head_d;
  logic              head_vld_d;

  assign brow_last = (brow_q == BR_W'(BAND - 1));
  assign want0     = (state_q == S_RUN) && ofm_port0_v;
  assign want1     = want0 && ofm_port1_v && !brow_last;
  assign pop       = wr_en_q && wr_ready;
  assign wr_ptr1   = wr_ptr_q + PTR_W'(1);

  assign addr0 = ADDR_W'(oc_q) * ADDR_W'(CO_STRIDE)
               + (ADDR_W'(band_q) * ADDR_W'(BAND) + ADDR_W'(brow_q)) * ADDR_W'(OFM_W)
               + ADDR_W'(tw_q) * ADDR_W'(TI) + ADDR_W'(ow_q);
  assign word0 = {addr0, ofm_port0};
  assign word1 = {addr0 + ADDR_W'(OFM_W), ofm_port1};

  always_comb begin
    proto = 1'b0;
    if (state_q == S_RUN)
      proto = (ofm_port1_v && !ofm_port0_v) || (ofm_port0_v && ofm_port1_v && brow_last);
    else
      proto = ofm_port0_v || ofm_port1_v;
  end

  // FIFO occupancy includes the output register, so free space counts a same-cycle pop
  always_comb begin
    remain     = count_q - CNT_W'(pop);
    free       = CNT_W'(FIFO_DEPTH) - remain;
    acc0       = want0 && (free != '0);
    acc1       = want1 && (free >= CNT_W'(2));
    ovf        = (want0 && !acc0) || (want1 && !acc1);
    count_d    = remain + CNT_W'(acc0) + CNT_W'(acc1);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(acc0) + PTR_W'(acc1);
    head_vld_d = 1'b0;
    head_d     = mem_q[rd_ptr_d];
    if (remain != '0) begin
      head_vld_d = 1'b1;
    end else if (acc0) begin
      head_vld_d = 1'b1;
      head_d     = word0;
    end
  end

  // Position counters advance for every port0 sample, even a dropped one
  always_comb begin
    ow_d     = ow_q;
    brow_d   = brow_q;
    tw_d     = tw_q;
    band_d   = band_q;
    oc_d     = oc_q;
    last     = 1'b0;
    brow_sum = brow_q + (want1 ? BR_W'(2) : BR_W'(1));
    if (want0) begin
      if (ow_q == OW_W'(TI - 1)) begin
        ow_d = '0;
        if (brow_sum >= BR_W'(BAND)) begin
          brow_d = '0;
          if (tw_q == TW_W'(TW_NUM - 1)) begin
            tw_d = '0;
            if (band_q == BD_W'(NB - 1)) begin
              band_d = '0;
              if (oc_q == OC_W'(NUM_CO - 1)) begin
                oc_d = '0;
                last = 1'b1;
              end else begin
                oc_d = oc_q + OC_W'(1);
              end
            end else begin
              band_d = band_q + BD_W'(1);
            end
          end else begin
            tw_d = tw_q + TW_W'(1);
          end
        end else begin
          brow_d = brow_sum;
        end
      end else begin
        ow_d = ow_q + OW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc0) mem_q[wr_ptr_q] <= word0;
    if (acc1) mem_q[wr_ptr1]  <= word1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_proto_q <= 1'b0;
      ow_q        <= '0;
      brow_q      <= '0;
      tw_q        <= '0;
      band_q      <= '0;
      oc_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (last) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (count_d == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (state_q == S_IDLE && start) begin
        err_ovf_q   <= 1'b0;
        err_proto_q <= 1'b0;
        ow_q        <= '0;
        brow_q      <= '0;
        tw_q        <= '0;
        band_q      <= '0;
        oc_q        <= '0;
      end else begin
        if (proto) err_proto_q <= 1'b1;
        if (ovf)   err_ovf_q   <= 1'b1;
        ow_q   <= ow_d;
        brow_q <= brow_d;
        tw_q   <= tw_d;
        band_q <= band_d;
        oc_q   <= oc_d;
      end

      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_en_q  <= head_vld_d;
      if (head_vld_d) begin
        wr_addr_q <= head_d[ENT_W-1:DATA_W];
        wr_data_q <= head_d[DATA_W-1:0];
      end
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = err_ovf_q;
  assign err_proto    = err_proto_q;

endmodule
`default_nettype wire

// File: tb/tb_ofm_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ofm_writer : directed bench for ofm_writer (TI=4, BAND=5, OFM_H=5, NUM_CO=1).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ofm_writer;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_start, a_p0v, a_p1v, a_wr_ready;
  logic [24:0] a_p0, a_p1;
  logic        a_wr_en, a_busy, a_done, a_eo, a_ep;
  logic [19:0] a_wr_addr;
  logic [24:0] a_wr_data;

  logic        b_start, b_p0v, b_p1v, b_wr_ready;
  logic [24:0] b_p0, b_p1;
  logic        b_wr_en, b_busy, b_done, b_eo, b_ep;
  logic [19:0] b_wr_addr;
  logic [24:0] b_wr_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [19:0] a_qa[$], b_qa[$];
  logic [24:0] a_qd[$], b_qd[$];
  int a_done_cnt = 0, b_done_cnt = 0;
  int a_last_wr = 0, a_done_cyc = 0;

  always #5 clk = ~clk;

  ofm_writer #(.DATA_W(25), .TI(4), .TW_NUM(1), .BAND(5), .OFM_H(5), .NUM_CO(1),
               .ADDR_W(20), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .rst(rst), .start(a_start),
    .ofm_port0(a_p0), .ofm_port0_v(a_p0v), .ofm_port1(a_p1), .ofm_port1_v(a_p1v),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
    .busy(a_busy), .done(a_done), .err_overflow(a_eo), .err_proto(a_ep));

  ofm_writer #(.DATA_W(25), .TI(4), .TW_NUM(2), .BAND(5), .OFM_H(5), .NUM_CO(1),
               .ADDR_W(20), .FIFO_DEPTH(8)) u_b (
    .clk(clk), .rst(rst), .start(b_start),
    .ofm_port0(b_p0), .ofm_port0_v(b_p0v), .ofm_port1(b_p1), .ofm_port1_v(b_p1v),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
    .busy(b_busy), .done(b_done), .err_overflow(b_eo), .err_proto(b_ep));

  // Inputs change at posedge+1, so the handshake seen at negedge commits on the next posedge
  always @(negedge clk) begin
    if (a_wr_en && a_wr_ready) begin
      a_qa.push_back(a_wr_addr);
      a_qd.push_back(a_wr_data);
      a_last_wr = cyc;
    end
    if (a_done) begin
      a_done_cnt++;
      a_done_cyc = cyc;
    end
    if (b_wr_en && b_wr_ready) begin
      b_qa.push_back(b_wr_addr);
      b_qd.push_back(b_wr_data);
    end
    if (b_done) b_done_cnt++;
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_done(input int budget);
    for (int i = 0; i < budget && a_done_cnt == 0; i++) tick();
  endtask

  task automatic wait_b_done(input int budget);
    for (int i = 0; i < budget && b_done_cnt == 0; i++) tick();
  endtask

  task automatic b_single(input int v);
    b_p0 = 25'(v); b_p0v = 1'b1; b_p1v = 1'b0;
    tick();
    b_p0v = 1'b0;
  endtask

  task automatic b_clear();
    b_qa.delete(); b_qd.delete(); b_done_cnt = 0;
  endtask

  // Single-sample tile order for TI=4, BAND=5, TW_NUM=2: ow fastest, then brow, then tw
  function automatic int exp_addr(input int k);
    return ((k / 4) % 5) * 8 + ((k / 20) % 2) * 4 + (k % 4);
  endfunction

  int t3_addr[17] = '{0, 8, 1, 9, 2, 10, 3, 11, 16, 17, 18, 19, 24, 25, 26, 27, 32};
  int t3_data[17] = '{0, 100, 1, 101, 2, 102, 3, 103,
                      200, 201, 202, 203, 204, 205, 206, 207, 300};

  initial begin
    rst = 1'b1;
    a_start = 0; a_p0v = 0; a_p1v = 0; a_p0 = '0; a_p1 = '0; a_wr_ready = 1;
    b_start = 0; b_p0v = 0; b_p1v = 0; b_p0 = '0; b_p1 = '0; b_wr_ready = 1;
    repeat (3) tick();

    check("rst_wr_en", b_wr_en, 0);
    check("rst_wr_addr", b_wr_addr, 0);
    check("rst_wr_data", b_wr_data, 0);
    check("rst_busy", b_busy, 0);
    check("rst_done", b_done, 0);
    check("rst_err_ovf", b_eo, 0);
    check("rst_err_proto", b_ep, 0);
    rst = 1'b0;
    tick();

    // Linear map: 20 samples, addr == data
    a_start = 1; tick(); a_start = 0;
    check("t1_busy", a_busy, 1);
    for (int k = 0; k < 20; k++) begin
      a_p0 = 25'(k); a_p0v = 1; tick();
    end
    a_p0v = 0;
    wait_a_done(40);
    repeat (3) tick();
    check("t1_done_cnt", a_done_cnt, 1);
    check("t1_done_lat", a_done_cyc - a_last_wr, 1);
    check("t1_busy_fall", a_busy, 0);
    check("t1_nwrites", a_qa.size(), 20);
    for (int k = 0; k < a_qa.size() && k < 20; k++) begin
      check($sformatf("t1_addr[%0d]", k), a_qa[k], k);
      check($sformatf("t1_data[%0d]", k), a_qd[k], k);
    end

    // Two tiles across: tile-order remapping
    b_clear();
    b_start = 1; tick(); b_start = 0;
    for (int k = 0; k < 40; k++) b_single(k);
    wait_b_done(40);
    tick();
    check("t2_done_cnt", b_done_cnt, 1);
    check("t2_nwrites", b_qa.size(), 40);
    if (b_qa.size() == 40) begin
      check("t2_s20", b_qa[20], 4);
      check("t2_s24", b_qa[24], 12);
      check("t2_s39", b_qa[39], 39);
      for (int k = 0; k < 40; k++) begin
        check($sformatf("t2_addr[%0d]", k), b_qa[k], exp_addr(k));
        check($sformatf("t2_data[%0d]", k), b_qd[k], k);
      end
    end
    check("t2_err_proto", b_ep, 0);

    // Pair mode, then a pair landing on the last band row
    b_clear();
    b_start = 1; tick(); b_start = 0;
    for (int k = 0; k < 4; k++) begin
      b_p0 = 25'(k); b_p1 = 25'(100 + k); b_p0v = 1; b_p1v = 1; tick();
    end
    b_p0v = 0; b_p1v = 0;
    for (int k = 0; k < 8; k++) b_single(200 + k);
    check("t3_proto_before", b_ep, 0);
    b_p0 = 25'd300; b_p1 = 25'd400; b_p0v = 1; b_p1v = 1; tick();
    b_p0v = 0; b_p1v = 0;
    check("t3_proto_after", b_ep, 1);
    repeat (12) tick();
    check("t3_nwrites", b_qa.size(), 17);
    for (int k = 0; k < b_qa.size() && k < 17; k++) begin
      check($sformatf("t3_addr[%0d]", k), b_qa[k], t3_addr[k]);
      check($sformatf("t3_data[%0d]", k), b_qd[k], t3_data[k]);
    end
    check("t3_busy", b_busy, 1);
    check("t3_no_ovf", b_eo, 0);
    rst = 1; tick(); rst = 0; tick();
    check("t3_rst_proto", b_ep, 0);

    // Valid while idle, start clears, port1-only ignored
    b_p0 = 25'd7; b_p0v = 1; tick(); b_p0v = 0;
    check("idle_valid_proto", b_ep, 1);
    b_start = 1; tick(); b_start = 0;
    check("start_clears_proto", b_ep, 0);
    b_p1 = 25'd55; b_p1v = 1; tick(); b_p1v = 0;
    check("p1_only_proto", b_ep, 1);
    check("p1_only_no_wr", b_wr_en, 0);

    // Overflow: 12 samples against a stalled memory
    b_clear();
    b_wr_ready = 0;
    for (int k = 0; k < 12; k++) b_single(500 + k);
    check("ovf_flag", b_eo, 1);
    check("ovf_wr_en", b_wr_en, 1);
    check("ovf_hold_addr", b_wr_addr, 0);
    check("ovf_hold_data", b_wr_data, 500);
    b_wr_ready = 1;
    repeat (12) tick();
    check("ovf_nwrites", b_qa.size(), 8);
    for (int k = 12; k < 16; k++) b_single(500 + k);
    repeat (6) tick();
    check("ovf_total", b_qa.size(), 12);
    for (int k = 0; k < b_qa.size() && k < 12; k++) begin
      check($sformatf("ovf_addr[%0d]", k), b_qa[k], (k < 8) ? exp_addr(k) : exp_addr(k + 4));
      check($sformatf("ovf_data[%0d]", k), b_qd[k], (k < 8) ? 500 + k : 504 + k);
    end
    check("ovf_sticky", b_eo, 1);

    // Asynchronous reset with words queued
    b_wr_ready = 0;
    for (int k = 0; k < 3; k++) b_single(600 + k);
    check("pre_rst_wr_en", b_wr_en, 1);
    #2 rst = 1;
    #1;
    check("rst_async_wr_en", b_wr_en, 0);
    check("rst_async_busy", b_busy, 0);
    tick();
    rst = 0;
    b_clear();
    b_wr_ready = 1;
    tick();
    b_start = 1; tick(); b_start = 0;
    b_single(777);
    repeat (3) tick();
    check("post_rst_nwrites", b_qa.size(), 1);
    if (b_qa.size() > 0) begin
      check("post_rst_addr", b_qa[0], 0);
      check("post_rst_data", b_qd[0], 777);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
